// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32 fields into 32-bit instruction words and
// writes them in order to IMEM through a two-stage (S1 capture, S2 write) pipe.
// Ports: clk/rst; in_valid/in_ready request with in_opcode, in_rd, in_rs1,
// in_rs2, in_funct3, in_funct7, in_imm; mem_we/mem_ready write handshake with
// mem_addr/mem_wdata; status wr_count, full, err (sticky), err_cnt (saturating).
module inst_encoder #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ARI  = 7'b0010011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_R    = 7'b0110011;

    logic              s1_valid;
    logic [6:0]        s1_op;
    logic [4:0]        s1_rd;
    logic [4:0]        s1_rs1;
    logic [4:0]        s1_rs2;
    logic [2:0]        s1_f3;
    logic [6:0]        s1_f7;
    logic [31:0]       s1_imm;

    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W:0]   resv;

    logic              legal;
    logic [31:0]       word;
    logic              s2_done;
    logic              s1_adv;
    logic              load_s2;
    logic              reject;
    logic              accept;

    // Immediate range checks: upper bits must be a pure sign extension.
    logic j_ok, b_ok, i_ok, sh_ok, u_ok, is_shift;

    assign j_ok     = (&s1_imm[31:20]) | ~(|s1_imm[31:20]);
    assign b_ok     = (&s1_imm[31:12]) | ~(|s1_imm[31:12]);
    assign i_ok     = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
    assign sh_ok    = ~(|s1_imm[31:5]);
    assign u_ok     = ~(|s1_imm[11:0]);
    assign is_shift = (s1_f3 == 3'b001) || (s1_f3 == 3'b101);

    always_comb begin
        legal = 1'b0;
        word  = '0;
        case (s1_op)
            OP_JAL: begin
                legal = j_ok & ~s1_imm[0];
                word  = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                         s1_imm[19:12], s1_rd, s1_op};
            end
            OP_BR: begin
                legal = b_ok & ~s1_imm[0];
                word  = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1,
                         s1_f3, s1_imm[4:1], s1_imm[11], s1_op};
            end
            OP_LD, OP_JALR: begin
                legal = i_ok;
                word  = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
            end
            OP_ARI: begin
                if (is_shift) begin
                    legal = sh_ok;
                    word  = {s1_f7, s1_imm[4:0], s1_rs1, s1_f3,
                             s1_rd, s1_op};
                end else begin
                    legal = i_ok;
                    word  = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
                end
            end
            OP_ST: begin
                legal = i_ok;
                word  = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3,
                         s1_imm[4:0], s1_op};
            end
            OP_LUI, OP_AUI: begin
                legal = u_ok;
                word  = {s1_imm[31:12], s1_rd, s1_op};
            end
            OP_R: begin
                legal = 1'b1;
                word  = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

    // An illegal S1 entry drains without needing S2, so it never stalls.
    assign s2_done  = mem_we && mem_ready;
    assign s1_adv   = s1_valid && (!mem_we || s2_done || !legal);
    assign load_s2  = s1_adv && legal;
    assign reject   = s1_adv && !legal;
    assign in_ready = !rst && (resv < DEPTH_V) && (!s1_valid || s1_adv);
    assign accept   = in_valid && in_ready;
    assign full     = (wr_count == DEPTH_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            next_addr <= BASE_ADDR;
            wr_count  <= '0;
            resv      <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (load_s2) begin
                mem_we    <= 1'b1;
                mem_addr  <= next_addr;
                mem_wdata <= word;
                next_addr <= next_addr + ADDR_W'(1);
            end else if (s2_done) begin
                mem_we <= 1'b0;
            end
            if (s2_done) begin
                wr_count <= wr_count + (ADDR_W+1)'(1);
            end
            resv <= resv + (ADDR_W+1)'(accept) - (ADDR_W+1)'(reject);
            if (reject) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op  <= in_opcode;
            s1_rd  <= in_rd;
            s1_rs1 <= in_rs1;
            s1_rs2 <= in_rs2;
            s1_f3  <= in_funct3;
            s1_f7  <= in_funct7;
            s1_imm <= in_imm;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed vector table, stall/full/reset sequences and a
// randomized run checked by decoding written words back to their fields.
module tb_inst_encoder;

    localparam logic [7:0] BASE = 8'h10;

    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] ARI = 7'b0010011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] RR  = 7'b0110011;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        req_t        r;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        mem_we, mem_ready, full, err;
    logic [7:0]  mem_addr, err_cnt;
    logic [31:0] mem_wdata;
    logic [8:0]  wr_count;

    logic        s_rst, s_in_valid, s_in_ready;
    logic        s_mem_we, s_mem_ready, s_full, s_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_wr_count;
    logic [7:0]  s_err_cnt;

    inst_encoder #(.ADDR_W(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm),
        .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .wr_count(wr_count), .full(full),
        .err(err), .err_cnt(err_cnt)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut_s (
        .clk(clk), .rst(s_rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm),
        .mem_we(s_mem_we), .mem_ready(s_mem_ready),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .wr_count(s_wr_count), .full(s_full),
        .err(s_err), .err_cnt(s_err_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Write monitors and hold-while-stalled checker
    logic [7:0]  w_addr[$];
    logic [31:0] w_data[$];
    logic [1:0]  sw_addr[$];
    logic [31:0] sw_data[$];
    logic        hold_we = 1'b0;
    logic [7:0]  hold_a;
    logic [31:0] hold_d;

    always @(posedge clk) begin
        if (hold_we && !rst) begin
            chk("hold_we", mem_we, 1'b1);
            chk("hold_addr", mem_addr, hold_a);
            chk("hold_data", mem_wdata, hold_d);
        end
        hold_we <= mem_we && !mem_ready && !rst;
        hold_a  <= mem_addr;
        hold_d  <= mem_wdata;
        if (mem_we && mem_ready && !rst) begin
            w_addr.push_back(mem_addr);
            w_data.push_back(mem_wdata);
        end
        if (s_mem_we && s_mem_ready && !s_rst) begin
            sw_addr.push_back(s_mem_addr);
            sw_data.push_back(s_mem_wdata);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic drive(input req_t r);
        in_opcode = r.op;
        in_rd     = r.rd;
        in_rs1    = r.rs1;
        in_rs2    = r.rs2;
        in_funct3 = r.f3;
        in_funct7 = r.f7;
        in_imm    = r.imm;
    endtask

    task automatic send(input req_t r);
        int n;
        drive(r);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready=0 exp=1");
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic s_send(input req_t r, input int lim, output bit acc);
        int n;
        drive(r);
        s_in_valid = 1'b1;
        n = 0;
        while (!s_in_ready && n < lim) begin
            @(negedge clk);
            n++;
        end
        acc = s_in_ready;
        if (acc) @(negedge clk);
        s_in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int k);
        int n;
        n = 0;
        while (w_data.size() < k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_count", w_data.size(), k);
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input bit lg,
                                input logic [31:0] wd);
        vec_t v;
        v.r     = '{op, rd, rs1, rs2, f3, f7, imm};
        v.legal = lg;
        v.word  = wd;
        return v;
    endfunction

    // Legality from the immediate's numeric range, not its bit pattern.
    function automatic bit model_legal(input req_t r);
        int s;
        s = int'(r.imm);
        case (r.op)
            JAL: return (s % 2 == 0) && s >= -(1 << 20) && s < (1 << 20);
            BR:  return (s % 2 == 0) && s >= -4096 && s < 4096;
            LD, JLR, ST: return s >= -2048 && s < 2048;
            ARI: begin
                if (r.f3 == 3'd1 || r.f3 == 3'd5) return r.imm < 32;
                return s >= -2048 && s < 2048;
            end
            LUI, AUI: return (r.imm % 4096) == 0;
            RR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] gen_imm(input logic [6:0] op,
                                            input logic [2:0] f3);
        int v;
        if ($urandom_range(0, 7) == 0) return $urandom;
        case (op)
            JAL: v = int'($urandom_range(0, (1 << 20) - 1)) * 2 - (1 << 20);
            BR:  v = int'($urandom_range(0, 4095)) * 2 - 4096;
            LD, JLR, ST: v = int'($urandom_range(0, 4095)) - 2048;
            ARI: begin
                if (f3 == 3'd1 || f3 == 3'd5) v = int'($urandom_range(0, 31));
                else v = int'($urandom_range(0, 4095)) - 2048;
            end
            LUI, AUI: v = int'($urandom & 32'hFFFFF000);
            default: v = int'($urandom);
        endcase
        return 32'(v);
    endfunction

    // Core immediate generator view of a written word.
    function automatic bit dec_ok(input logic [31:0] w, input req_t r);
        logic [31:0] imm;
        bit ok;
        ok = (w[6:0] == r.op);
        case (r.op)
            JAL: begin
                imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                ok &= (imm == r.imm) && (w[11:7] == r.rd);
            end
            BR: begin
                imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                ok &= (imm == r.imm) && (w[19:15] == r.rs1)
                    && (w[24:20] == r.rs2) && (w[14:12] == r.f3);
            end
            ST: begin
                imm = {{20{w[31]}}, w[31:25], w[11:7]};
                ok &= (imm == r.imm) && (w[19:15] == r.rs1)
                    && (w[24:20] == r.rs2) && (w[14:12] == r.f3);
            end
            LUI, AUI: begin
                imm = {w[31:12], 12'b0};
                ok &= (imm == r.imm) && (w[11:7] == r.rd);
            end
            RR: begin
                ok &= (w[31:25] == r.f7) && (w[24:20] == r.rs2)
                    && (w[19:15] == r.rs1) && (w[14:12] == r.f3)
                    && (w[11:7] == r.rd);
            end
            default: begin
                if (r.op == ARI && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
                    imm = {27'b0, w[24:20]};
                    ok &= (w[31:25] == r.f7);
                end else begin
                    imm = {{20{w[31]}}, w[31:20]};
                end
                ok &= (imm == r.imm) && (w[19:15] == r.rs1)
                    && (w[14:12] == r.f3) && (w[11:7] == r.rd);
            end
        endcase
        return ok;
    endfunction

    vec_t        vt[16];
    logic [7:0]  exp_a[$];
    logic [31:0] exp_w[$];
    req_t        rq[$];
    logic [6:0]  ops[11];
    int          nchk;
    int          nerr;
    int          nrej;
    bit          done;
    bit          acc;
    int          base_n;

    task automatic check_writes();
        for (int k = nchk; k < exp_w.size() && k < w_data.size(); k++) begin
            chk($sformatf("waddr%0d", k), w_addr[k], exp_a[k]);
            chk($sformatf("wdata%0d", k), w_data[k], exp_w[k]);
        end
        nchk = exp_w.size();
    endtask

    task automatic push_exp(input int i);
        if (vt[i].legal) begin
            exp_a.push_back(8'(BASE + 8'(exp_w.size())));
            exp_w.push_back(vt[i].word);
        end else begin
            nerr++;
        end
    endtask

    initial begin
        vt[0]  = mk(BR,  5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h3,        0, 32'h0);
        vt[1]  = mk(BR,  5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h1000,     0, 32'h0);
        vt[2]  = mk(LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1,        0, 32'h0);
        vt[3]  = mk(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0,      0, 32'h0);
        vt[4]  = mk(ARI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1, 32'hFFF00093);
        vt[5]  = mk(ST,  5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC, 1, 32'hFE21AE23);
        vt[6]  = mk(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,      1, 32'h001000EF);
        vt[7]  = mk(LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 32'h123452B7);
        vt[8]  = mk(ARI, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'h3,       1, 32'h4030D093);
        vt[9]  = mk(BR,  5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1, 32'hFE208EE3);
        vt[10] = mk(RR,  5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 1, 32'h002081B3);
        vt[11] = mk(ARI, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'h20,       0, 32'h0);
        vt[12] = mk(ARI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,      0, 32'h0);
        vt[13] = mk(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h801,      0, 32'h0);
        vt[14] = mk(ARI, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 1, 32'h80000113);
        vt[15] = mk(JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000FFFFE, 1, 32'h7FFFF06F);
        ops = '{JAL, BR, LD, JLR, ARI, ST, LUI, AUI, RR, 7'h7F, 7'h73};
        nchk = 0;
        nerr = 0;

        rst = 1'b1;
        s_rst = 1'b1;
        in_valid = 1'b0;
        s_in_valid = 1'b0;
        mem_ready = 1'b1;
        s_mem_ready = 1'b1;
        drive(vt[3].r);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_wr_count", wr_count, 9'd0);
        chk("rst_full", full, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        rst = 1'b0;
        s_rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1'b1);
        @(negedge clk);

        // Illegal requests only: no write, address not consumed
        for (int i = 0; i < 4; i++) begin
            send(vt[i].r);
            push_exp(i);
        end
        repeat (4) @(negedge clk);
        chk("rej_err", err, 1'b1);
        chk("rej_err_cnt", err_cnt, 8'(nerr));
        chk("rej_no_write", w_data.size(), 0);
        chk("rej_wr_count", wr_count, 9'd0);

        // Latency: accept at edge N, mem_we visible after edge N+1
        send(vt[4].r);
        push_exp(4);
        chk("lat_before", mem_we, 1'b0);
        send(vt[5].r);
        push_exp(5);
        chk("lat_after", mem_we, 1'b1);
        chk("lat_addr", mem_addr, BASE);
        chk("lat_data", mem_wdata, vt[4].word);

        for (int i = 6; i < 16; i++) begin
            send(vt[i].r);
            push_exp(i);
        end
        wait_writes(exp_w.size());
        repeat (2) @(negedge clk);
        check_writes();
        chk("tab_err_cnt", err_cnt, 8'(nerr));

        // Stall: mem_ready low while four requests are offered
        mem_ready = 1'b0;
        fork
            begin
                for (int i = 6; i < 10; i++) begin
                    send(vt[i].r);
                    push_exp(i);
                end
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall_we", mem_we, 1'b1);
                chk("stall_ready", in_ready, 1'b0);
                chk("stall_addr", mem_addr, 8'(BASE + 8'd9));
                @(negedge clk);
                chk("stall_ready2", in_ready, 1'b0);
                @(posedge clk);
                #2 mem_ready = 1'b1;
            end
        join
        wait_writes(exp_w.size());
        check_writes();

        // Randomized run with random mem_ready back-pressure
        base_n = w_data.size();
        nrej = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    req_t r;
                    r.op  = ops[$urandom_range(0, 10)];
                    r.rd  = 5'($urandom);
                    r.rs1 = 5'($urandom);
                    r.rs2 = 5'($urandom);
                    r.f3  = 3'($urandom);
                    r.f7  = 7'($urandom);
                    r.imm = gen_imm(r.op, r.f3);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    if (model_legal(r)) rq.push_back(r);
                    else nrej++;
                    send(r);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2 mem_ready = ($urandom_range(0, 3) != 0);
                end
                mem_ready = 1'b1;
            end
        join
        wait_writes(base_n + rq.size());
        repeat (3) @(negedge clk);
        for (int k = 0; k < rq.size() && base_n + k < w_data.size(); k++) begin
            total++;
            if (w_addr[base_n + k] !== 8'(BASE + 8'(base_n + k))
                || !dec_ok(w_data[base_n + k], rq[k])) begin
                bad++;
                $display("FAIL rand%0d addr=%h word=%h exp addr=%h op=%b imm=%h",
                         k, w_addr[base_n + k], w_data[base_n + k],
                         8'(BASE + 8'(base_n + k)), rq[k].op, rq[k].imm);
            end
        end
        chk("rand_err_cnt", err_cnt, 8'(nerr + nrej));
        chk("rand_wr_count", wr_count, 9'(base_n + rq.size()));

        // Error counter saturation
        for (int i = 0; i < 250; i++) send(vt[3].r);
        repeat (3) @(negedge clk);
        chk("err_sat", err_cnt, 8'hFF);
        chk("err_sat_wr", wr_count, 9'(base_n + rq.size()));

        // Small instance: capacity 4
        s_send(vt[3].r, 20, acc);
        chk("s_rej_acc", acc, 1'b1);
        for (int i = 0; i < 6; i++) begin
            s_send(vt[4 + i].r, 20, acc);
            chk($sformatf("s_acc%0d", i), acc, (i < 4));
            if (i == 3) chk("s_ready_resv", s_in_ready, 1'b0);
        end
        repeat (3) @(negedge clk);
        chk("s_writes", sw_data.size(), 4);
        for (int k = 0; k < 4 && k < sw_data.size(); k++) begin
            chk($sformatf("s_addr%0d", k), sw_addr[k], k);
            chk($sformatf("s_data%0d", k), sw_data[k], vt[4 + k].word);
        end
        chk("s_full", s_full, 1'b1);
        chk("s_wr_count", s_wr_count, 3'd4);
        chk("s_err", s_err, 1'b1);
        chk("s_full_we", s_mem_we, 1'b0);

        s_rst = 1'b1;
        @(negedge clk);
        chk("s_rst_ready", s_in_ready, 1'b0);
        chk("s_rst_we", s_mem_we, 1'b0);
        chk("s_rst_addr", s_mem_addr, 2'd0);
        chk("s_rst_wdata", s_mem_wdata, 32'h0);
        chk("s_rst_wr_count", s_wr_count, 3'd0);
        chk("s_rst_full", s_full, 1'b0);
        chk("s_rst_err", s_err, 1'b0);
        chk("s_rst_err_cnt", s_err_cnt, 8'd0);
        s_rst = 1'b0;
        #1;
        chk("s_post_rst_ready", s_in_ready, 1'b1);
        @(negedge clk);

        // Reset while a word waits in S2: it must be dropped
        s_mem_ready = 1'b0;
        s_send(vt[8].r, 5, acc);
        @(negedge clk);
        chk("s_mid_we", s_mem_we, 1'b1);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        s_mem_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("s_mid_dropped", sw_data.size(), 4);
        chk("s_mid_we_low", s_mem_we, 1'b0);
        s_send(vt[9].r, 5, acc);
        repeat (3) @(negedge clk);
        chk("s_after_writes", sw_data.size(), 5);
        if (sw_data.size() == 5) begin
            chk("s_after_addr", sw_addr[4], 2'd0);
            chk("s_after_data", sw_data[4], vt[9].word);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
